switch_control: RTL and testbench

SWITCH_CONTROL -- requirements
Module: switch_control

---
 rtl/switch_control_pkg.sv | 22 ++
 rtl/switch_control_xy_route_calc.sv | 29 ++
 rtl/switch_control.sv | 166 ++++++++++++++++
 tb/tb_switch_control.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_control_pkg.sv
// Shared constants and types for the router switch controller.
// Holds port indices, default sizes and the arbitration FSM encoding.
package switch_control_pkg;

    localparam int NPORT_DEF    = 5;
    localparam int TAM_FLIT_DEF = 16;
    localparam int IDX_W        = 3;

    localparam logic [IDX_W-1:0] EAST  = 3'd0;
    localparam logic [IDX_W-1:0] WEST  = 3'd1;
    localparam logic [IDX_W-1:0] NORTH = 3'd2;
    localparam logic [IDX_W-1:0] SOUTH = 3'd3;
    localparam logic [IDX_W-1:0] LOCAL = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARB   = 2'd1,
        S_ROUTE = 2'd2,
        S_GRANT = 2'd3
    } state_e;

endpackage

// File: rtl/switch_control_xy_route_calc.sv
// XY routing decision: resolve X first, then Y, else deliver locally.
// Ports: target (header X/Y), address (router X/Y), port (output index).
module xy_route_calc
    import switch_control_pkg::*;
(
    input  logic [7:0]       target,
    input  logic [7:0]       address,
    output logic [IDX_W-1:0] port
);

    logic [3:0] tx, ty, lx, ly;

    assign tx = target[7:4];
    assign ty = target[3:0];
    assign lx = address[7:4];
    assign ly = address[3:0];

    always_comb begin
        port = LOCAL;
        unique case (1'b1)
            (tx > lx):               port = EAST;
            (tx < lx):               port = WEST;
            (tx == lx && ty > ly):   port = NORTH;
            (tx == lx && ty < ly):   port = SOUTH;
            default:                 port = LOCAL;
        endcase
    end

endmodule

// File: rtl/switch_control.sv
// Router switch controller: arbitrates header requests, routes XY, allocates outputs.
// Ports: clock, reset (async low); h/data_in/sender/address in; ack_h/mux_in/mux_out/free out.
module switch_control
    import switch_control_pkg::*;
#(
    parameter int NPORT    = NPORT_DEF,
    parameter int TAM_FLIT = TAM_FLIT_DEF
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NPORT-1:0]          h,
    input  logic [NPORT*TAM_FLIT-1:0] data_in,
    input  logic [NPORT-1:0]          sender,
    input  logic [7:0]                address,
    output logic [NPORT-1:0]          ack_h,
    output logic [NPORT*IDX_W-1:0]    mux_in,
    output logic [NPORT*IDX_W-1:0]    mux_out,
    output logic [NPORT-1:0]          free
);

    // Assert asynchronously, release on the second clock edge.
    logic rst_meta_q, rst_sync_q, rst_n;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    assign rst_n = rst_sync_q;

    state_e state_q, state_d;

    logic [NPORT-1:0]       ack_q, ack_d;
    logic [NPORT-1:0]       free_q, free_d;
    logic [NPORT-1:0]       blocked_q, blocked_d;
    logic [NPORT*IDX_W-1:0] mux_in_q, mux_in_d;
    logic [NPORT*IDX_W-1:0] mux_out_q, mux_out_d;
    logic [IDX_W-1:0]       sel_q, sel_d;
    logic [IDX_W-1:0]       dest_q, dest_d;
    logic [7:0]             hdr_q, hdr_d;

    logic [NPORT-1:0] req;
    logic [NPORT-1:0] rel;
    logic [IDX_W-1:0] pick;
    logic [7:0]       hdr_pick;
    logic [IDX_W-1:0] route_port;

    // Only the target byte of each header is consumed.
    logic unused_hdr;
    assign unused_hdr = ^data_in;

    assign req = h & ~blocked_q;

    // Lowest index wins: scan downward so the last hit is the smallest.
    always_comb begin
        pick     = '0;
        hdr_pick = '0;
        for (int i = NPORT - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick     = IDX_W'(i);
                hdr_pick = data_in[i*TAM_FLIT +: 8];
            end
        end
    end

    // An allocated output frees itself once its source stops sending.
    always_comb begin
        rel = '0;
        for (int o = 0; o < NPORT; o++) begin
            rel[o] = !free_q[o] && !sender[mux_in_q[o*IDX_W +: IDX_W]];
        end
    end

    xy_route_calc u_xy (
        .target  (hdr_q),
        .address (address),
        .port    (route_port)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (|req) state_d = S_ARB;
            S_ARB:   state_d = S_ROUTE;
            S_ROUTE: state_d = S_GRANT;
            S_GRANT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Grant looks at the pre-release free bit; a same-cycle release
    // still lands and wipes the blocked mask it would have set.
    always_comb begin
        ack_d     = '0;
        free_d    = free_q | rel;
        blocked_d = blocked_q;
        mux_in_d  = mux_in_q;
        mux_out_d = mux_out_q;
        sel_d     = sel_q;
        dest_d    = dest_q;
        hdr_d     = hdr_q;
        unique case (state_q)
            S_ARB: begin
                sel_d = pick;
                hdr_d = hdr_pick;
            end
            S_ROUTE: begin
                dest_d = route_port;
            end
            S_GRANT: begin
                if (free_q[dest_q]) begin
                    free_d[dest_q]                  = 1'b0;
                    mux_in_d[dest_q*IDX_W +: IDX_W] = sel_q;
                    mux_out_d[sel_q*IDX_W +: IDX_W] = dest_q;
                    ack_d[sel_q]                    = 1'b1;
                end else begin
                    blocked_d[sel_q] = 1'b1;
                end
            end
            default: begin
            end
        endcase
        if (|rel) blocked_d = '0;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            ack_q     <= '0;
            free_q    <= '1;
            blocked_q <= '0;
            mux_in_q  <= '0;
            mux_out_q <= '0;
            sel_q     <= '0;
            dest_q    <= '0;
            hdr_q     <= '0;
        end else begin
            ack_q     <= ack_d;
            free_q    <= free_d;
            blocked_q <= blocked_d;
            mux_in_q  <= mux_in_d;
            mux_out_q <= mux_out_d;
            sel_q     <= sel_d;
            dest_q    <= dest_d;
            hdr_q     <= hdr_d;
        end
    end

    assign ack_h   = ack_q;
    assign free    = free_q;
    assign mux_in  = mux_in_q;
    assign mux_out = mux_out_q;

endmodule

// File: tb/tb_switch_control.sv
// Scoreboard bench for switch_control: directed rounds, timed ack and state checks.
// Ports: drives all DUT inputs, observes ack_h/free/mux_in/mux_out.
module tb_switch_control;
    import switch_control_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  h;
    logic [79:0] data_in;
    logic [4:0]  sender;
    logic [7:0]  address;
    logic [4:0]  ack_h;
    logic [14:0] mux_in;
    logic [14:0] mux_out;
    logic [4:0]  free;

    switch_control #(.NPORT(5), .TAM_FLIT(16)) dut (
        .clock   (clock),
        .reset   (reset),
        .h       (h),
        .data_in (data_in),
        .sender  (sender),
        .address (address),
        .ack_h   (ack_h),
        .mux_in  (mux_in),
        .mux_out (mux_out),
        .free    (free)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int           cyc;
        logic [127:0] nm;
        logic [4:0]   ack;
        logic [4:0]   free;
        int           sel;
        int           dest;
    } ack_exp_t;

    typedef struct {
        int           cyc;
        logic [127:0] nm;
        logic [4:0]   free;
        bit           mux;
    } st_exp_t;

    ack_exp_t aq[$];
    st_exp_t  sq[$];
    int checks = 0;
    int errors = 0;
    bit done = 0;

    task automatic chk(input logic [127:0] nm, input string fld,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %0s.%s: got %0h expected %0h", nm, fld, act, exp);
        end
    endtask

    // Monitor: compare DUT outputs against queued expectations.
    initial begin
        ack_exp_t e;
        st_exp_t  s;
        forever begin
            @(negedge clock);
            if (ack_h != 5'b0) begin
                if (aq.size() == 0) begin
                    chk("unexpected", "ack", 32'(ack_h), 32'd0);
                end else begin
                    e = aq.pop_front();
                    chk(e.nm, "cycle", 32'(cyc), 32'(e.cyc));
                    chk(e.nm, "ack", 32'(ack_h), 32'(e.ack));
                    chk(e.nm, "free", 32'(free), 32'(e.free));
                    chk(e.nm, "mux_out", 32'(mux_out[e.sel*3 +: 3]), 32'(e.dest));
                    chk(e.nm, "mux_in", 32'(mux_in[e.dest*3 +: 3]), 32'(e.sel));
                end
            end else if (aq.size() > 0 && aq[0].cyc <= cyc) begin
                e = aq.pop_front();
                chk(e.nm, "missing_ack", 32'(ack_h), 32'(e.ack));
            end
            while (sq.size() > 0 && sq[0].cyc <= cyc) begin
                s = sq.pop_front();
                chk(s.nm, "free", 32'(free), 32'(s.free));
                chk(s.nm, "ack", 32'(ack_h), 32'd0);
                if (s.mux) begin
                    chk(s.nm, "mux_in", 32'(mux_in), 32'd0);
                    chk(s.nm, "mux_out", 32'(mux_out), 32'd0);
                end
            end
            if (done) begin
                while (aq.size() > 0) begin
                    e = aq.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL %0s.timeout: no ack by cycle %0d", e.nm, e.cyc);
                end
                while (sq.size() > 0) begin
                    s = sq.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL %0s.timeout: check at cycle %0d not reached", s.nm, s.cyc);
                end
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // Input-buffer model: drop h and start sending once acknowledged.
    task automatic tick();
        @(posedge clock);
        #1;
        for (int i = 0; i < 5; i++) begin
            if (ack_h[i]) begin
                h[i]      = 1'b0;
                sender[i] = 1'b1;
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic set_hdr(input int i, input logic [7:0] t);
        data_in[i*16 +: 16] = {8'h00, t};
    endtask

    task automatic exp_ack(input logic [127:0] nm, input int c,
                           input int sel, input int dest, input logic [4:0] fr);
        ack_exp_t e;
        e.cyc  = c;
        e.nm   = nm;
        e.ack  = 5'b00001 << sel;
        e.free = fr;
        e.sel  = sel;
        e.dest = dest;
        aq.push_back(e);
    endtask

    task automatic exp_st(input logic [127:0] nm, input int c,
                          input logic [4:0] fr, input bit mx);
        st_exp_t s;
        s.cyc  = c;
        s.nm   = nm;
        s.free = fr;
        s.mux  = mx;
        sq.push_back(s);
    endtask

    initial begin
        int n;
        reset   = 1'b0;
        h       = '0;
        sender  = '0;
        data_in = '0;
        address = 8'h11;
        exp_st("reset_a", 1, 5'b11111, 1'b1);
        exp_st("reset_b", 2, 5'b11111, 1'b1);
        ticks(3);
        reset = 1'b1;
        ticks(3);

        // Single LOCAL request routed east.
        n = cyc;
        set_hdr(4, 8'h21);
        h = 5'b10000;
        exp_ack("r030", n + 4, 4, 0, 5'b11110);
        exp_st("r030_hold", n + 5, 5'b11110, 1'b0);
        exp_st("r030_rel", n + 6, 5'b11111, 1'b0);
        ticks(5);
        sender[4] = 1'b0;
        ticks(2);

        // Two requests for LOCAL: east wins, west blocks until release.
        n = cyc;
        set_hdr(0, 8'h11);
        set_hdr(1, 8'h11);
        h = 5'b00011;
        exp_ack("r031_east", n + 4, 0, 4, 5'b01111);
        exp_st("r031_blocked", n + 9, 5'b01111, 1'b0);
        exp_st("r031_rel", n + 11, 5'b11111, 1'b0);
        exp_ack("r031_west", n + 15, 1, 4, 5'b01111);
        exp_st("r031_rel2", n + 17, 5'b11111, 1'b0);
        ticks(10);
        sender[0] = 1'b0;
        ticks(6);
        sender[1] = 1'b0;
        ticks(2);

        // Release and grant of LOCAL on the same edge.
        n = cyc;
        set_hdr(0, 8'h11);
        h = 5'b00001;
        exp_ack("r032_first", n + 4, 0, 4, 5'b01111);
        ticks(4);
        set_hdr(1, 8'h11);
        h[1] = 1'b1;
        ticks(3);
        sender[0] = 1'b0;
        exp_st("r032_collide", n + 8, 5'b11111, 1'b0);
        exp_ack("r032_second", n + 12, 1, 4, 5'b01111);
        exp_st("r032_rel", n + 14, 5'b11111, 1'b0);
        ticks(6);
        sender[1] = 1'b0;
        ticks(2);

        // Reset pulse while the FSM is routing.
        n = cyc;
        set_hdr(2, 8'h21);
        h = 5'b00100;
        ticks(2);
        exp_st("r033_in_rst", n + 2, 5'b11111, 1'b1);
        exp_st("r033_after", n + 5, 5'b11111, 1'b1);
        reset = 1'b0;
        h     = '0;
        #2;
        reset = 1'b1;
        ticks(4);

        // All five inputs to five distinct outputs.
        n = cyc;
        set_hdr(0, 8'h21);
        set_hdr(1, 8'h01);
        set_hdr(2, 8'h12);
        set_hdr(3, 8'h10);
        set_hdr(4, 8'h11);
        h = 5'b11111;
        exp_ack("r034_p0", n + 4, 0, 0, 5'b11110);
        exp_ack("r034_p1", n + 8, 1, 1, 5'b11100);
        exp_ack("r034_p2", n + 12, 2, 2, 5'b11000);
        exp_ack("r034_p3", n + 16, 3, 3, 5'b10000);
        exp_ack("r034_p4", n + 20, 4, 4, 5'b00000);
        exp_st("r034_full", n + 21, 5'b00000, 1'b0);
        exp_st("r034_rel_all", n + 22, 5'b11111, 1'b0);
        ticks(21);
        sender = '0;
        ticks(3);
        done = 1'b1;
    end

endmodule
